// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path: opcodes and sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_MUL   = 4'h2;
    localparam logic [3:0] OP_DIV   = 4'h3;
    localparam logic [3:0] OP_SHLA  = 4'h4;
    localparam logic [3:0] OP_SHRA  = 4'h5;
    localparam logic [3:0] OP_SHLB2 = 4'h6;
    localparam logic [3:0] OP_ROL   = 4'h7;
    localparam logic [3:0] OP_ROR   = 4'h8;
    localparam logic [3:0] OP_AND   = 4'h9;
    localparam logic [3:0] OP_OR    = 4'hA;
    localparam logic [3:0] OP_NOT   = 4'hB;
    localparam logic [3:0] OP_XOR   = 4'hC;
    localparam logic [3:0] OP_XNOR  = 4'hD;
    localparam logic [3:0] OP_GT    = 4'hE;
    localparam logic [3:0] OP_EQ    = 4'hF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int unsigned SETTLE_W = 4;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Command-side master for the 4-bit ALU: registers operands, waits a settle
// time, captures the result and returns it over a valid/ready handshake.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_sel,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic             cmd_chain,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_sel,
    input  logic [7:0]       alu_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_y,
    output logic             rsp_zero,
    output logic [3:0]       rsp_sel,
    output logic [CNT_W-1:0] op_count
);

    logic [1:0]          state_q,     state_d;
    logic [SETTLE_W-1:0] cnt_q,       cnt_d;
    logic [7:0]          acc_q,       acc_d;
    logic [3:0]          alu_a_q,     alu_a_d;
    logic [3:0]          alu_b_q,     alu_b_d;
    logic [3:0]          alu_sel_q,   alu_sel_d;
    logic [7:0]          rsp_y_q,     rsp_y_d;
    logic                rsp_zero_q,  rsp_zero_d;
    logic [3:0]          rsp_sel_q,   rsp_sel_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic [CNT_W-1:0]    op_count_q,  op_count_d;

    // State and datapath registers; reset aborts any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_y_q     <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_sel_q   <= '0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_y_q     <= rsp_y_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_sel_q   <= rsp_sel_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            op_count_q  <= op_count_d;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        rsp_y_d    = rsp_y_q;
        rsp_zero_d = rsp_zero_q;
        rsp_sel_d  = rsp_sel_q;
        op_count_d = op_count_q;

        case (state_q)
            ST_IDLE: begin
                // cmd_ready_q gates the accept so nothing is taken in the first cycle after reset
                if (cmd_ready_q && cmd_valid) begin
                    alu_a_d   = cmd_chain ? acc_q[3:0] : cmd_a;
                    alu_b_d   = cmd_b;
                    alu_sel_d = cmd_sel;
                    cnt_d     = SETTLE_W'(SETTLE_CYCLES - 1);
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_y_d    = alu_y;
                    rsp_zero_d = (alu_y == 8'h00);
                    rsp_sel_d  = alu_sel_q;
                    acc_d      = alu_y;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    assign cmd_ready = cmd_ready_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_sel   = rsp_sel_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench: two sequencer instances (settle 1 / 16-bit count, settle 3 / 4-bit count) each driving a behavioural ALU.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid [2];
    logic       rsp_ready [2];
    logic [3:0] cmd_sel, cmd_a, cmd_b;
    logic       cmd_chain;

    logic       cmd_ready [2];
    logic       rsp_valid [2];
    logic       rsp_zero  [2];
    logic [3:0] alu_a     [2];
    logic [3:0] alu_b     [2];
    logic [3:0] alu_sel   [2];
    logic [3:0] rsp_sel   [2];
    logic [7:0] alu_y     [2];
    logic [7:0] rsp_y     [2];
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
        case (sel)
            OP_ADD:  alu_f = {4'h0, a} + {4'h0, b};
            OP_SUB:  alu_f = {4'h0, a} - {4'h0, b};
            OP_MUL:  alu_f = {4'h0, a} * {4'h0, b};
            OP_AND:  alu_f = {4'h0, a & b};
            OP_OR:   alu_f = {4'h0, a | b};
            OP_XOR:  alu_f = {4'h0, a ^ b};
            OP_GT:   alu_f = {7'd0, a > b};
            OP_EQ:   alu_f = {7'd0, a == b};
            default: alu_f = 8'h00;
        endcase
    endfunction

    assign alu_y[0] = alu_f(alu_a[0], alu_b[0], alu_sel[0]);
    assign alu_y[1] = alu_f(alu_a[1], alu_b[1], alu_sel[1]);

    alu_cmd_sequencer #(.SETTLE_CYCLES(1), .CNT_W(16)) u_seq0 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_sel(alu_sel[0]), .alu_y(alu_y[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_y(rsp_y[0]), .rsp_zero(rsp_zero[0]), .rsp_sel(rsp_sel[0]),
        .op_count(cnt0)
    );

    alu_cmd_sequencer #(.SETTLE_CYCLES(3), .CNT_W(4)) u_seq1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_sel(alu_sel[1]), .alu_y(alu_y[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_y(rsp_y[1]), .rsp_zero(rsp_zero[1]), .rsp_sel(rsp_sel[1]),
        .op_count(cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] count_of(input int k);
        count_of = (k == 0) ? cnt0 : {12'd0, cnt1};
    endfunction

    // Issue one command, check the ALU operand, latency and captured response.
    task automatic run_op(input int k, input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b,
                          input logic chain, input logic [7:0] exp_y, input logic [3:0] exp_a,
                          input int exp_lat, input string tag);
        int n;
        int lat;
        @(negedge clk);
        cmd_sel = sel; cmd_a = a; cmd_b = b; cmd_chain = chain;
        cmd_valid[k] = 1'b1;
        n = 0;
        while (!cmd_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        cmd_valid[k] = 1'b0;
        cmd_sel = ~sel; cmd_a = ~a; cmd_b = ~b; cmd_chain = ~chain;
        chk({tag, "_alu_a"}, 32'(alu_a[k]), 32'(exp_a));
        lat = 0;
        while (!rsp_valid[k] && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rsp_y"}, 32'(rsp_y[k]), 32'(exp_y));
        chk({tag, "_rsp_zero"}, 32'(rsp_zero[k]), 32'(exp_y == 8'h00));
        chk({tag, "_rsp_sel"}, 32'(rsp_sel[k]), 32'(sel));
    endtask

    // Wait out the response handshake (rsp_ready already high).
    task automatic hs(input int k, input logic [15:0] exp_cnt, input string tag);
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, 32'(rsp_valid[k]), 32'd0);
        chk({tag, "_op_count"}, 32'(count_of(k)), 32'(exp_cnt));
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid[0] = 1'b0; cmd_valid[1] = 1'b0;
        rsp_ready[0] = 1'b1; rsp_ready[1] = 1'b1;
        cmd_sel = '0; cmd_a = '0; cmd_b = '0; cmd_chain = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready[0]), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rst_op_count", 32'(cnt0), 32'd0);
        chk("rst_alu_a", 32'(alu_a[0]), 32'd0);
        chk("rst_rsp_y", 32'(rsp_y[1]), 32'd0);
        rst = 1'b0;

        run_op(0, OP_ADD, 4'h7, 4'h9, 1'b0, 8'h10, 4'h7, 1, "add");
        hs(0, 16'd1, "add");
        run_op(0, OP_ADD, 4'hF, 4'h3, 1'b1, 8'h03, 4'h0, 1, "chain");
        hs(0, 16'd2, "chain");
        run_op(0, OP_EQ, 4'h5, 4'h5, 1'b0, 8'h01, 4'h5, 1, "eq");
        hs(0, 16'd3, "eq");

        // Backpressure: response must hold and a new command must not be taken.
        rsp_ready[0] = 1'b0;
        run_op(0, OP_AND, 4'hA, 4'h5, 1'b0, 8'h00, 4'hA, 1, "and");
        @(negedge clk);
        cmd_sel = OP_ADD; cmd_a = 4'h3; cmd_b = 4'h3; cmd_chain = 1'b0;
        cmd_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
            chk("bp_rsp_y", 32'(rsp_y[0]), 32'h00);
            chk("bp_rsp_sel", 32'(rsp_sel[0]), 32'(OP_AND));
            chk("bp_cmd_ready", 32'(cmd_ready[0]), 32'd0);
        end
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        hs(0, 16'd4, "bp");
        repeat (4) @(posedge clk);
        #1;
        chk("bp_no_accept_valid", 32'(rsp_valid[0]), 32'd0);
        chk("bp_no_accept_sel", 32'(alu_sel[0]), 32'(OP_AND));

        // Reset while in WAIT.
        @(negedge clk);
        cmd_sel = OP_ADD; cmd_a = 4'h1; cmd_b = 4'h1; cmd_chain = 1'b0;
        cmd_valid[0] = 1'b1;
        @(posedge clk); #1;
        cmd_valid[0] = 1'b0;
        chk("mid_alu_a", 32'(alu_a[0]), 32'd1);
        chk("mid_in_wait", 32'(rsp_valid[0]), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_alu_a", 32'(alu_a[0]), 32'd0);
        chk("mid_rst_alu_b", 32'(alu_b[0]), 32'd0);
        chk("mid_rst_op_count", 32'(cnt0), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready[0]), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op(0, OP_ADD, 4'hF, 4'h2, 1'b1, 8'h02, 4'h0, 1, "post_rst");
        hs(0, 16'd1, "post_rst");

        // Settle time of 3 cycles.
        run_op(1, OP_MUL, 4'hF, 4'hF, 1'b0, 8'hE1, 4'hF, 3, "mul");
        hs(1, 16'd1, "mul");

        // Counter wrap at 4 bits.
        for (int i = 0; i < 14; i++) begin
            run_op(1, OP_ADD, 4'(i), 4'h1, 1'b0, alu_f(4'(i), 4'h1, OP_ADD), 4'(i), 3, "wrap_op");
            @(posedge clk); #1;
        end
        chk("wrap_15", 32'(cnt1), 32'd15);
        run_op(1, OP_XOR, 4'h6, 4'h3, 1'b0, 8'h05, 4'h6, 3, "wrap_a");
        hs(1, 16'd0, "wrap_a");
        run_op(1, OP_SUB, 4'h9, 4'h4, 1'b0, 8'h05, 4'h9, 3, "wrap_b");
        hs(1, 16'd1, "wrap_b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
